// File: rtl/hft_pkg.sv
// Shared order-path definitions: signal encodings, side bytes, message length, TX FSM states.
// Message length grows to 9 bytes when ORDER_TX_CHECKSUM_EN is defined.
package hft_pkg;

  localparam logic [1:0] SIG_NONE = 2'b00;
  localparam logic [1:0] SIG_BUY  = 2'b01;
  localparam logic [1:0] SIG_SELL = 2'b10;
  localparam logic [1:0] SIG_FLAT = 2'b11;

  localparam logic [7:0] SIDE_BUY  = 8'h01;
  localparam logic [7:0] SIDE_SELL = 8'h02;
  localparam logic [7:0] SIDE_FLAT = 8'h03;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

`ifdef ORDER_TX_CHECKSUM_EN
  localparam int unsigned MSG_LEN = 9;
`else
  localparam int unsigned MSG_LEN = 8;
`endif
  localparam int unsigned MSG_W = MSG_LEN * 8;

  typedef enum logic {StIdle, StSend} tx_state_e;

  function automatic logic [7:0] side_byte(input logic [1:0] sig);
    logic [7:0] b;
    case (sig)
      SIG_BUY:  b = SIDE_BUY;
      SIG_SELL: b = SIDE_SELL;
      SIG_FLAT: b = SIDE_FLAT;
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous FIFO; a push while full is taken when a pop happens in the same cycle.
module order_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/order_tx_engine.sv
// Buffers alpha-core orders and serialises each into a fixed byte message on a valid/ready stream.
// Define ORDER_TX_CHECKSUM_EN to append an XOR checksum byte to every message.
module order_tx_engine
  import hft_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRICE_W    = 32,
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               order_valid,
  input  logic [1:0]         order_signal,
  input  logic [PRICE_W-1:0] order_price,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               fifo_full,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        sent_cnt,
  output logic               busy
);

  localparam int unsigned ENT_W = PRICE_W + 2;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]  LAST_IDX = 4'(MSG_LEN - 1);

  logic [ENT_W-1:0] head;
  logic             fifo_empty, push, pop, hs, last_hs;
  logic [CW-1:0]    fifo_count;
  logic [15:0]      msg_seq;

  tx_state_e        state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [3:0]       idx_q, idx_d;
  logic [15:0]      seq_q, seq_d, sent_q, sent_d, drop_q, drop_d;
  logic             tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;

  order_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({order_signal, order_price}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  function automatic logic [MSG_W-1:0] build_msg(input logic [ENT_W-1:0] ent,
                                                 input logic [15:0] seq);
    logic [63:0] base;
    base = {HDR_BYTE, side_byte(ent[ENT_W-1 -: 2]), seq, ent[PRICE_W-1:0]};
`ifdef ORDER_TX_CHECKSUM_EN
    begin
      logic [7:0] csum;
      csum = 8'h00;
      for (int i = 0; i < 7; i++) csum ^= base[i*8 +: 8];
      return {base, csum};
    end
`else
    return base;
`endif
  endfunction

  assign push    = order_valid && (order_signal != SIG_NONE);
  assign hs      = tx_valid_q && tx_ready;
  assign last_hs = hs && tx_last_q;
  // Next order is loaded either from idle or on the closing handshake, so messages abut.
  assign pop     = !fifo_empty && ((state_q == StIdle) || last_hs);
  assign msg_seq = last_hs ? seq_q + 16'd1 : seq_q;

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    sent_d     = sent_q;
    drop_d     = drop_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;

    if (last_hs) begin
      sent_d     = sent_q + 16'd1;
      seq_d      = seq_q + 16'd1;
      state_d    = StIdle;
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
    end else if (hs) begin
      msg_d     = msg_q << 8;
      idx_d     = idx_q + 4'd1;
      tx_last_d = (idx_q + 4'd1 == LAST_IDX);
    end

    if (pop) begin
      msg_d      = build_msg(head, msg_seq);
      idx_d      = 4'd0;
      state_d    = StSend;
      tx_valid_d = 1'b1;
      tx_last_d  = 1'b0;
    end

    if (push && fifo_full && !pop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      msg_q      <= '0;
      idx_q      <= '0;
      seq_q      <= '0;
      sent_q     <= '0;
      drop_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      sent_q     <= sent_d;
      drop_q     <= drop_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign tx_data  = msg_q[MSG_W-1 -: 8];
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign drop_cnt = drop_q;
  assign sent_cnt = sent_q;
  assign busy     = (fifo_count != '0) || (state_q == StSend);

endmodule
